// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
//
// Shared constants for the DES initial / final permutation pipeline.
//
//   MODE_IP / MODE_FP  : encodings of the in_mode port of des_perm_pipe
//   IP_TABLE           : DES initial permutation, entry i-1 holds IP[i]
//   FP_TABLE           : DES final permutation (IP^-1), entry i-1 holds FP[i]
//   des_permute_ip()   : apply IP to a 64-bit block
//   des_permute_fp()   : apply FP to a 64-bit block
//
// Bit numbering: DES bit 1 is vector bit [63], DES bit 64 is vector bit [0],
// so DES bit n lives at vector index 64-n.
// ---------------------------------------------------------------------------
package des_pkg;

    localparam logic MODE_IP = 1'b0;
    localparam logic MODE_FP = 1'b1;

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Output DES bit (i+1) takes input DES bit IP_TABLE[i]; the loop
    // unrolls into pure wiring.
    function automatic logic [63:0] des_permute_ip(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[63 - i] = x[64 - IP_TABLE[i]];
        end
        return r;
    endfunction

    function automatic logic [63:0] des_permute_fp(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[63 - i] = x[64 - FP_TABLE[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// ---------------------------------------------------------------------------
// des_perm_stage
//
// One register slice of the permutation pipeline: a valid bit plus the
// 64-bit block and its sideband tag, with ready/valid flow control.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   up_valid   : upstream offers a block
//   up_data    : upstream block
//   up_tag     : upstream tag
//   up_ready   : this slice can take a block this cycle
//   dn_valid   : this slice holds a block
//   dn_data    : held block
//   dn_tag     : held tag
//   dn_ready   : downstream takes the held block this cycle
// ---------------------------------------------------------------------------
module des_perm_stage
    import des_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [63:0]      up_data,
    input  logic [TAG_W-1:0] up_tag,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [63:0]      dn_data,
    output logic [TAG_W-1:0] dn_tag,
    input  logic             dn_ready
);

    // The slice can take a block when it is empty or when its current block
    // leaves in the same cycle. This depends only on local state and the
    // downstream ready, never on up_valid.
    assign up_ready = !dn_valid || dn_ready;

    // Payload only loads on a real transfer, so data and tag stay frozen
    // while the slice is stalled or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_tag   <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
                dn_tag  <= up_tag;
            end
        end
    end

endmodule

// File: rtl/des_perm_pipe.sv
// ---------------------------------------------------------------------------
// des_perm_pipe
//
// Pipelined DES initial permutation (IP) / final permutation (FP = IP^-1)
// with ready/valid handshakes on both sides and a tag carried alongside
// each block.
//
// Parameters
//   STAGES : number of register slices (1..4); result appears STAGES cycles
//            after acceptance when out_ready is held high
//   TAG_W  : width of the sideband tag
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input block present
//   in_ready   : block accepted when in_valid && in_ready
//   in_mode    : 0 = IP, 1 = FP
//   in_data    : 64-bit block, DES bit 1 at [63]
//   in_tag     : opaque sideband
//   out_valid  : result present
//   out_ready  : result consumed when out_valid && out_ready
//   out_data   : permuted block
//   out_tag    : tag of the same transaction
//   busy       : any slice holds a block
//
// Build option
//   DES_PERM_FP_EN : when defined, in_mode selects FP; otherwise in_mode is
//                    ignored and every block gets IP.
// ---------------------------------------------------------------------------
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [63:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [63:0] perm_data;

    // Index 0 is the input side, index STAGES is the output side; slice g
    // sits between index g and g+1.
    logic [STAGES:0] valid_chain;
    logic [STAGES:0] ready_chain;
    logic [63:0]     data_chain [STAGES+1];
    logic [TAG_W-1:0] tag_chain [STAGES+1];

    // The permutation is applied before the first slice, so the mode only
    // ever affects the block it arrived with and need not be stored.
`ifdef DES_PERM_FP_EN
    always_comb begin
        perm_data = des_permute_ip(in_data);
        if (in_mode == MODE_FP) begin
            perm_data = des_permute_fp(in_data);
        end
    end
`else
    logic mode_unused;
    assign mode_unused = in_mode;
    assign perm_data   = des_permute_ip(in_data);
`endif

    assign valid_chain[0] = in_valid;
    assign data_chain[0]  = perm_data;
    assign tag_chain[0]   = in_tag;

    // The last slice drains on out_ready; each earlier slice sees the ready
    // of the one after it, which gives the full-throughput skid-free chain.
    assign ready_chain[STAGES] = out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        des_perm_stage #(
            .TAG_W (TAG_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (valid_chain[g]),
            .up_data  (data_chain[g]),
            .up_tag   (tag_chain[g]),
            .up_ready (ready_chain[g]),
            .dn_valid (valid_chain[g+1]),
            .dn_data  (data_chain[g+1]),
            .dn_tag   (tag_chain[g+1]),
            .dn_ready (ready_chain[g+1])
        );
    end

    assign in_ready  = ready_chain[0];
    assign out_valid = valid_chain[STAGES];
    assign out_data  = data_chain[STAGES];
    assign out_tag   = tag_chain[STAGES];
    assign busy      = |valid_chain[STAGES:1];

endmodule
